uart_controller: RTL and testbench
==================================

Name: uart_controller

Overview:
- 8N1 UART sitting directly downstream of the MMIO mapper.
- Consumes the mapper's transmit strobe/data and "data has been read" strobe.
- Produces the received byte and 3-bit status {rx_data_valid, tx_active, tx_done} that the mapper returns to the CPU.
- Contains a TX serializer, an RX deserializer with one-byte hold register, and per-direction bit-timing counters.

Parameters:
- CLKS_PER_BIT, 868, clock cycles per bit period (100 MHz / 115200); legal values >= 4.

Ports:
- in_clk  input  1  system clock, all logic on rising edge
- in_reset_n  input  1  asynchronous active-low reset
- in_send_en  input  1  write strobe for TX data (mapper out_uart_send_en)
- in_tx_data  input  32  TX data; only [7:0] used (mapper out_uart_data)
- in_data_is_read  input  1  CPU acknowledges RX byte (mapper out_uart_data_is_read)
- in_rx  input  1  serial receive line, asynchronous, idle high
- out_tx  output  1  serial transmit line, idle high
- out_rx_data  output  8  RX hold register (to mapper in_uart_data)
- out_status  output  3  {rx_data_valid, tx_active, tx_done} (to mapper in_uart_status)

Behaviour:
- Reset (async assert, sync release): out_tx=1, out_rx_data=0, out_status=3'b000, both FSMs in IDLE, counters 0.
- Frame format: 1 start (0), 8 data LSB first, 1 stop (1). No parity.
- TX FSM: IDLE -> START -> DATA -> STOP -> IDLE.
  - Accept: in_send_en high this cycle, low the previous cycle (rising-edge detect), and FSM in IDLE. Latch in_tx_data[7:0].
  - Accepted cycle+1: START, out_tx=0, tx_active=1, tx_done=0.
  - Each state lasts exactly CLKS_PER_BIT cycles; DATA shifts 8 bits.
  - End of STOP: IDLE, tx_active=0, tx_done=1.
  - tx_done is sticky until the next accepted send.
  - Full frame is 10*CLKS_PER_BIT cycles of tx_active.
  - in_send_en while not IDLE is ignored: no queueing, latched byte unchanged.
- RX path:
  - in_rx passes through a 2-FF synchronizer, reset to 1.
  - RX FSM: IDLE -> START -> DATA -> STOP -> IDLE.
  - IDLE: synchronized line low -> START.
  - START: sample at CLKS_PER_BIT/2 (integer divide). If line is high, treat as glitch and return to IDLE; else DATA.
  - DATA: sample 8 bits, one every CLKS_PER_BIT cycles at bit centres, shift in LSB first.
  - STOP: sample at centre.
    - Stop=1: next cycle out_rx_data = byte and rx_data_valid=1. FSM returns to IDLE immediately after the stop sample, so it can detect the next start edge.
    - Stop=0 (framing error): discard byte, out_rx_data and rx_data_valid unchanged, FSM -> IDLE.
- rx_data_valid clear:
  - in_data_is_read high: next cycle rx_data_valid=0; out_rx_data retains its value.
- Boundary conditions:
  - Overrun (byte completes while valid=1): overwrite out_rx_data, valid stays 1.
  - Completion and in_data_is_read in the same cycle: new byte loaded, valid=1 (completion wins).
  - in_data_is_read with valid=0: no effect.
- Reset mid-frame: out_tx returns to 1 asynchronously; any partial RX byte is discarded; status=000.
- TX and RX are fully independent; simultaneous activity is allowed.

Optional Feature:
- Macro: UART_LOOPBACK_EN.
- Defined:
  - Adds input port in_loopback (1 bit).
  - When in_loopback=1, the RX synchronizer input is taken from the internal TX serial line instead of in_rx, and out_tx is forced to 1.
  - in_loopback must change only while both FSMs are IDLE; behaviour is otherwise undefined.
- Not defined: port absent; RX always from in_rx.

Test Plan:
- TX timing:
  - Stimulus: CLKS_PER_BIT=4; pulse in_send_en for 1 cycle with in_tx_data=0x00000055.
  - Response: out_tx pattern 0,1,0,1,0,1,0,1,0,1, each bit held 4 cycles, starting the cycle after the pulse.
  - tx_active high for 40 cycles, then status=3'b001.
- RX receive:
  - Stimulus: drive 8N1 frame for 0xA3 on in_rx.
  - Response: out_rx_data=0xA3, out_status[2]=1.
  - Then pulse in_data_is_read: out_status[2]=0 next cycle, out_rx_data still 0xA3.
- Overrun:
  - Stimulus: receive 0x11, then 0x22 without acknowledging.
  - Response: out_rx_data=0x22, valid=1.
  - Also: completion of 0x33 in the same cycle as in_data_is_read -> valid=1, data=0x33.
- Framing error and glitch:
  - Frame 0x5A with stop bit 0 -> no valid, data unchanged.
  - A low pulse of 1 cycle (< CLKS_PER_BIT/2) on in_rx -> ignored.
  - A following good frame 0x5A -> received correctly.
- Busy and hold:
  - Send 0x41, then pulse in_send_en with 0x42 mid-frame -> only 0x41 is transmitted.
  - Holding in_send_en high for 50 cycles -> exactly one frame.
- Reset mid-operation:
  - Assert in_reset_n=0 during TX bit 3 and RX bit 5.
  - Response: out_tx=1 immediately, status=000, out_rx_data=0.
  - A subsequent 0x7E send/receive completes correctly.

Source files
------------

// File: rtl/uart_controller.sv
// uart_controller: 8N1 UART behind the MMIO mapper.
// TX serializer plus RX deserializer with a one-byte hold register.
// Status is {rx_data_valid, tx_active, tx_done}.
// Optional feature macro: UART_LOOPBACK_EN (adds in_loopback; RX fed from TX).
module uart_controller #(
   parameter int unsigned CLKS_PER_BIT = 868
) (
   input  logic        in_clk,
   input  logic        in_reset_n,
   input  logic        in_send_en,
   input  logic [31:0] in_tx_data,
   input  logic        in_data_is_read,
   input  logic        in_rx,
`ifdef UART_LOOPBACK_EN
   input  logic        in_loopback,
`endif
   output logic        out_tx,
   output logic [7:0]  out_rx_data,
   output logic [2:0]  out_status
);

   localparam int unsigned CNT_W    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam int unsigned BIT_LAST = CLKS_PER_BIT - 1;
   localparam int unsigned HALF_M1  = (CLKS_PER_BIT / 2) - 1;

   typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

   state_t             r_tx_state, w_tx_next;
   logic [CNT_W-1:0]   r_tx_cnt;
   logic [2:0]         r_tx_bit;
   logic [7:0]         r_tx_shift;
   logic               r_tx, r_tx_active, r_tx_done, r_send_en_d;

   state_t             r_rx_state, w_rx_next;
   logic [CNT_W-1:0]   r_rx_cnt;
   logic [2:0]         r_rx_bit;
   logic [7:0]         r_rx_shift, r_rx_data;
   logic               r_rx_meta, r_rx_sync, r_rx_valid;

   logic               w_tx_accept, w_tx_bit_end;
   logic               w_rx_half, w_rx_full, w_rx_sample, w_rx_line_in, w_rx_done;
   logic               w_unused_tx_data;

   assign w_unused_tx_data = ^in_tx_data[31:8];

   assign w_tx_accept  = in_send_en && !r_send_en_d && (r_tx_state == S_IDLE);
   assign w_tx_bit_end = (r_tx_cnt == CNT_W'(BIT_LAST));

`ifdef UART_LOOPBACK_EN
   assign w_rx_line_in = in_loopback ? r_tx : in_rx;
   assign out_tx       = in_loopback ? 1'b1 : r_tx;
`else
   assign w_rx_line_in = in_rx;
   assign out_tx       = r_tx;
`endif

   assign out_rx_data = r_rx_data;
   assign out_status  = {r_rx_valid, r_tx_active, r_tx_done};

   // TX state register
   always_ff @(posedge in_clk or negedge in_reset_n) begin
      if (!in_reset_n) r_tx_state <= S_IDLE;
      else             r_tx_state <= w_tx_next;
   end

   // TX next-state: each non-idle state lasts one bit period, DATA lasts eight
   always_comb begin
      w_tx_next = r_tx_state;
      case (r_tx_state)
         S_IDLE:  if (w_tx_accept)  w_tx_next = S_START;
         S_START: if (w_tx_bit_end) w_tx_next = S_DATA;
         S_DATA:  if (w_tx_bit_end && (r_tx_bit == 3'd7)) w_tx_next = S_STOP;
         S_STOP:  if (w_tx_bit_end) w_tx_next = S_IDLE;
         default: w_tx_next = S_IDLE;
      endcase
   end

   // TX datapath: bit timer, shifter, registered line and status flags
   always_ff @(posedge in_clk or negedge in_reset_n) begin
      if (!in_reset_n) begin
         r_tx_cnt    <= '0;
         r_tx_bit    <= '0;
         r_tx_shift  <= '0;
         r_tx        <= 1'b1;
         r_tx_active <= 1'b0;
         r_tx_done   <= 1'b0;
         r_send_en_d <= 1'b0;
      end else begin
         r_send_en_d <= in_send_en;
         if (r_tx_state == S_IDLE) begin
            r_tx_cnt <= '0;
            r_tx_bit <= '0;
            if (w_tx_accept) begin
               r_tx_shift  <= in_tx_data[7:0];
               r_tx        <= 1'b0;
               r_tx_active <= 1'b1;
               r_tx_done   <= 1'b0;
            end
         end else if (w_tx_bit_end) begin
            r_tx_cnt <= '0;
            case (r_tx_state)
               S_START: r_tx <= r_tx_shift[0];
               S_DATA: begin
                  r_tx_bit   <= r_tx_bit + 3'd1;
                  r_tx_shift <= {1'b0, r_tx_shift[7:1]};
                  r_tx       <= (r_tx_bit == 3'd7) ? 1'b1 : r_tx_shift[1];
               end
               S_STOP: begin
                  r_tx        <= 1'b1;
                  r_tx_active <= 1'b0;
                  r_tx_done   <= 1'b1;
               end
               default: r_tx <= 1'b1;
            endcase
         end else begin
            r_tx_cnt <= r_tx_cnt + CNT_W'(1);
         end
      end
   end

   // RX line synchronizer, idles high
   always_ff @(posedge in_clk or negedge in_reset_n) begin
      if (!in_reset_n) begin
         r_rx_meta <= 1'b1;
         r_rx_sync <= 1'b1;
      end else begin
         r_rx_meta <= w_rx_line_in;
         r_rx_sync <= r_rx_meta;
      end
   end

   assign w_rx_half   = (r_rx_cnt == CNT_W'(HALF_M1));
   assign w_rx_full   = (r_rx_cnt == CNT_W'(BIT_LAST));
   assign w_rx_sample = ((r_rx_state == S_START) && w_rx_half) ||
                        (((r_rx_state == S_DATA) || (r_rx_state == S_STOP)) && w_rx_full);
   assign w_rx_done   = (r_rx_state == S_STOP) && w_rx_full && r_rx_sync;

   // RX state register
   always_ff @(posedge in_clk or negedge in_reset_n) begin
      if (!in_reset_n) r_rx_state <= S_IDLE;
      else             r_rx_state <= w_rx_next;
   end

   // RX next-state: half-bit start check rejects glitches, then centre sampling
   always_comb begin
      w_rx_next = r_rx_state;
      case (r_rx_state)
         S_IDLE:  if (!r_rx_sync) w_rx_next = S_START;
         S_START: if (w_rx_half)  w_rx_next = r_rx_sync ? S_IDLE : S_DATA;
         S_DATA:  if (w_rx_full && (r_rx_bit == 3'd7)) w_rx_next = S_STOP;
         S_STOP:  if (w_rx_full)  w_rx_next = S_IDLE;
         default: w_rx_next = S_IDLE;
      endcase
   end

   // RX bit timer and LSB-first shifter
   always_ff @(posedge in_clk or negedge in_reset_n) begin
      if (!in_reset_n) begin
         r_rx_cnt   <= '0;
         r_rx_bit   <= '0;
         r_rx_shift <= '0;
      end else if (r_rx_state == S_IDLE) begin
         r_rx_cnt <= '0;
         r_rx_bit <= '0;
      end else if (w_rx_sample) begin
         r_rx_cnt <= '0;
         if (r_rx_state == S_DATA) begin
            r_rx_shift <= {r_rx_sync, r_rx_shift[7:1]};
            r_rx_bit   <= r_rx_bit + 3'd1;
         end
      end else begin
         r_rx_cnt <= r_rx_cnt + CNT_W'(1);
      end
   end

   // RX hold register: a completed byte wins over a simultaneous read ack
   always_ff @(posedge in_clk or negedge in_reset_n) begin
      if (!in_reset_n) begin
         r_rx_data  <= '0;
         r_rx_valid <= 1'b0;
      end else if (w_rx_done) begin
         r_rx_data  <= r_rx_shift;
         r_rx_valid <= 1'b1;
      end else if (in_data_is_read) begin
         r_rx_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_uart_controller.sv
// Testbench for uart_controller: directed plus randomized frames checked
// against a frame-level model of the transmitted waveform and RX hold register.
module tb_uart_controller;

   localparam int CPB = 4;

   logic        in_clk = 1'b0;
   logic        in_reset_n;
   logic        in_send_en;
   logic [31:0] in_tx_data;
   logic        in_data_is_read;
   logic        in_rx;
   logic        out_tx;
   logic [7:0]  out_rx_data;
   logic [2:0]  out_status;

   int checks = 0;
   int errors = 0;

   logic       rxq[$];
   logic [7:0] exp_data;
   logic       exp_valid;

   uart_controller #(.CLKS_PER_BIT(CPB)) dut (
      .in_clk          (in_clk),
      .in_reset_n      (in_reset_n),
      .in_send_en      (in_send_en),
      .in_tx_data      (in_tx_data),
      .in_data_is_read (in_data_is_read),
      .in_rx           (in_rx),
      .out_tx          (out_tx),
      .out_rx_data     (out_rx_data),
      .out_status      (out_status)
   );

   always #5 in_clk = ~in_clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // advance one cycle, then drive the next queued RX line level
   task automatic tick();
      @(negedge in_clk);
      in_rx = (rxq.size() != 0) ? rxq.pop_front() : 1'b1;
   endtask

   task automatic idle(input int n);
      repeat (n) tick();
   endtask

   task automatic rx_push(input logic [7:0] b, input logic stop);
      logic [9:0] fr;
      fr = {stop, b, 1'b0};
      for (int i = 0; i < 10; i++)
         repeat (CPB) rxq.push_back(fr[i]);
   endtask

   task automatic check_rx(input string tag);
      check({tag, "_data"}, 32'(out_rx_data), 32'(exp_data));
      check({tag, "_valid"}, 32'(out_status[2]), 32'(exp_valid));
   endtask

   task automatic send_pulse(input logic [7:0] b, input logic keep);
      in_send_en = 1'b1;
      in_tx_data = {24'h0, b};
      tick();
      if (!keep) in_send_en = 1'b0;
   endtask

   // expects frame of byte b on out_tx; optionally drives in_send_en in [en_from,en_to)
   task automatic run_tx(input logic [7:0] b, input int en_from, input int en_to,
                         input logic [7:0] other);
      logic [9:0] fr;
      fr = {1'b1, b, 1'b0};
      for (int i = 0; i < 10 * CPB; i++) begin
         if (i >= en_from && i < en_to) begin
            in_send_en = 1'b1;
            in_tx_data = {24'h0, other};
         end else begin
            in_send_en = 1'b0;
         end
         check("tx_line", 32'(out_tx), 32'(fr[i / CPB]));
         check("tx_busy", 32'(out_status[1:0]), 32'h2);
         tick();
      end
      check("tx_end_status", 32'(out_status[1:0]), 32'h1);
      check("tx_end_line", 32'(out_tx), 32'h1);
   endtask

   initial begin
      logic       found;
      logic [7:0] rb, tb_byte;
      logic       stop;

      in_reset_n = 1'b0;
      in_send_en = 1'b0;
      in_tx_data = '0;
      in_data_is_read = 1'b0;
      in_rx = 1'b1;
      exp_data = 8'h00;
      exp_valid = 1'b0;
      repeat (3) @(negedge in_clk);
      check("rst_tx", 32'(out_tx), 32'h1);
      check("rst_status", 32'(out_status), 32'h0);
      check("rst_data", 32'(out_rx_data), 32'h0);
      in_reset_n = 1'b1;
      idle(2);

      // TX timing with 0x55
      send_pulse(8'h55, 1'b0);
      run_tx(8'h55, 0, 0, 8'h00);
      idle(3);
      check("tx_done_sticky", 32'(out_status[1:0]), 32'h1);

      // RX receive and acknowledge
      rx_push(8'hA3, 1'b1);
      idle(10 * CPB + 8);
      exp_data = 8'hA3; exp_valid = 1'b1;
      check_rx("rx_a3");
      in_data_is_read = 1'b1;
      tick();
      in_data_is_read = 1'b0;
      exp_valid = 1'b0;
      check_rx("rx_ack");
      in_data_is_read = 1'b1;
      tick();
      in_data_is_read = 1'b0;
      check_rx("rx_ack_idle");

      // overrun
      rx_push(8'h11, 1'b1);
      idle(10 * CPB + 8);
      exp_data = 8'h11; exp_valid = 1'b1;
      check_rx("rx_11");
      rx_push(8'h22, 1'b1);
      idle(10 * CPB + 8);
      exp_data = 8'h22;
      check_rx("rx_overrun");

      // completion coinciding with a read acknowledge
      in_data_is_read = 1'b1;
      rx_push(8'h33, 1'b1);
      found = 1'b0;
      for (int i = 0; i < 20 * CPB && !found; i++) begin
         tick();
         if (out_rx_data === 8'h33) begin
            found = 1'b1;
            in_data_is_read = 1'b0;
         end
      end
      in_data_is_read = 1'b0;
      check("same_cycle_seen", 32'(found), 32'h1);
      idle(4);
      exp_data = 8'h33; exp_valid = 1'b1;
      check_rx("rx_same_cycle");
      in_data_is_read = 1'b1;
      tick();
      in_data_is_read = 1'b0;
      exp_valid = 1'b0;

      // framing error, glitch, then a good frame
      rx_push(8'h5A, 1'b0);
      idle(10 * CPB + 10);
      check_rx("rx_framing");
      rxq.push_back(1'b0);
      idle(6 * CPB);
      check_rx("rx_glitch");
      rx_push(8'h5A, 1'b1);
      idle(10 * CPB + 8);
      exp_data = 8'h5A; exp_valid = 1'b1;
      check_rx("rx_5a");

      // second send request mid-frame is dropped
      send_pulse(8'h41, 1'b0);
      run_tx(8'h41, 12, 13, 8'h42);
      idle(2 * CPB);
      check("busy_no_queue_line", 32'(out_tx), 32'h1);
      check("busy_no_queue_status", 32'(out_status[1:0]), 32'h1);

      // held send strobe yields exactly one frame
      send_pulse(8'hC6, 1'b1);
      run_tx(8'hC6, 0, 10 * CPB, 8'hC6);
      for (int i = 0; i < 9; i++) begin
         in_send_en = 1'b1;
         check("hold_line", 32'(out_tx), 32'h1);
         check("hold_status", 32'(out_status[1:0]), 32'h1);
         tick();
      end
      in_send_en = 1'b0;
      for (int i = 0; i < 8; i++) begin
         check("hold_after_line", 32'(out_tx), 32'h1);
         tick();
      end

      // randomized concurrent TX and RX
      for (int n = 0; n < 6; n++) begin
         rb = 8'($urandom_range(0, 255));
         tb_byte = 8'($urandom_range(0, 255));
         stop = ($urandom_range(0, 3) != 0);
         if ($urandom_range(0, 1) == 1) begin
            in_data_is_read = 1'b1;
            tick();
            in_data_is_read = 1'b0;
            exp_valid = 1'b0;
         end
         rx_push(rb, stop);
         send_pulse(tb_byte, 1'b0);
         run_tx(tb_byte, 0, 0, 8'h00);
         idle(12);
         if (stop) begin
            exp_data = rb;
            exp_valid = 1'b1;
         end
         check_rx("rx_rand");
      end

      // reset mid-frame: TX in data bit 3, RX around data bit 5
      rx_push(8'hC3, 1'b1);
      idle(8);
      send_pulse(8'hA5, 1'b0);
      idle(17);
      check("pre_rst_tx", 32'(out_tx), 32'h0);
      in_reset_n = 1'b0;
      rxq.delete();
      in_rx = 1'b1;
      #1;
      check("midrst_tx", 32'(out_tx), 32'h1);
      check("midrst_status", 32'(out_status), 32'h0);
      check("midrst_data", 32'(out_rx_data), 32'h0);
      idle(3);
      in_reset_n = 1'b1;
      exp_data = 8'h00; exp_valid = 1'b0;
      idle(2);
      check_rx("post_rst");
      rx_push(8'h7E, 1'b1);
      send_pulse(8'h7E, 1'b0);
      run_tx(8'h7E, 0, 0, 8'h00);
      idle(12);
      exp_data = 8'h7E; exp_valid = 1'b1;
      check_rx("rx_7e");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
